// File: rtl/io_entry_pkg.sv
// Shared types, mode codes and page-count helpers for the front-panel entry controller.
package io_entry_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_M_CLEAR,
      S_M_WRITE,
      S_M_READ,
      S_ENTRY,
      S_ISSUE,
      S_WAIT,
      S_SHOW
   } state_t;

   localparam logic [1:0] MODE_CLEAR = 2'b00;
   localparam logic [1:0] MODE_READ  = 2'b01;
   localparam logic [1:0] MODE_WRITE = 2'b10;
   localparam logic [1:0] MODE_IDLE  = 2'b11;

   // Number of 4*sw_n-bit pages needed to cover a field of the given width.
   function automatic int pages(input int width, input int sw_n);
      return (width + 4 * sw_n - 1) / (4 * sw_n);
   endfunction

   // Mode code shown for a mode state; anything else reports CLEAR.
   function automatic logic [1:0] mode_code(input state_t s);
      case (s)
         S_M_WRITE: return MODE_WRITE;
         S_M_READ:  return MODE_READ;
         S_IDLE:    return MODE_IDLE;
         default:   return MODE_CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/io_edge_det.sv
// Registered rising-edge detector: rise_o is high while an input is high
// but was low at the previous clock sample.
module io_edge_det #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] sig_i,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] prev_q;

   // Remember the previous sample of every input.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) prev_q <= '0;
      else       prev_q <= sig_i;
   end

   assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/io_entry_ctrl.sv
// Front-panel controller: paged hex entry of address/data from switches,
// CLEAR/WRITE/READ requests to memory with a req/done handshake, readback
// display and a watchdog on the memory response.
module io_entry_ctrl
   import io_entry_pkg::*;
#(
   parameter int ADDR_W  = 25,
   parameter int DATA_W  = 16,
   parameter int SW_N    = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_mode,
   input  logic              key_step,
   input  logic [SW_N-1:0]   sw,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        mode_out,
   output logic [3:0]        stage_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic              mem_clr,
   output logic [4*SW_N-1:0] disp_data,
   output logic              io_done,
   output logic              io_err
);

   localparam int PG_W  = 4 * SW_N;
   localparam int APG   = pages(ADDR_W, SW_N);
   localparam int DPG   = pages(DATA_W, SW_N);
   localparam int NPG   = APG + DPG;
   localparam int NDIG  = NPG * SW_N;
   localparam int TOT_W = NPG * PG_W;
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   // Bits of the flat digit store that map onto real address/data bits.
   function automatic logic [TOT_W-1:0] valid_mask();
      logic [TOT_W-1:0] m;
      m = '0;
      for (int i = 0; i < TOT_W; i++) begin
         if (i < ADDR_W || (i >= APG * PG_W && i < APG * PG_W + DATA_W)) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Zero-extend or truncate read data to one display page.
   function automatic logic [PG_W-1:0] fit_page(input logic [DATA_W-1:0] d);
      logic [PG_W+DATA_W-1:0] ext;
      ext = {{PG_W{1'b0}}, d};
      return ext[PG_W-1:0];
   endfunction

   localparam logic [TOT_W-1:0] DIG_MASK = valid_mask();

   state_t            state_q;
   state_t            owner_q;
   logic [3:0]        page_q;
   logic [TOT_W-1:0]  digits_q;
   logic [TOT_W-1:0]  digits_inc;
   logic [PG_W-1:0]   rd_q;
   logic [WD_W-1:0]   wd_q;
   logic              mem_req_q, mem_we_q, mem_clr_q, io_done_q, io_err_q;
   logic [SW_N+1:0]   rise;
   logic              mode_rise, step_rise;
   logic [SW_N-1:0]   sw_rise;
   logic [3:0]        last_pg;

   io_edge_det #(.W(SW_N + 2)) u_edge (
      .clk_i  (clk),
      .rst_i  (rst),
      .sig_i  ({sw, key_step, key_mode}),
      .rise_o (rise)
   );

   assign mode_rise = rise[0];
   assign step_rise = rise[1];
   assign sw_rise   = rise[SW_N+1:2];

   // Last page index: writes walk address then data pages, reads address pages only.
   assign last_pg = (owner_q == S_M_WRITE) ? 4'(NPG - 1) : 4'(APG - 1);

   // Per-digit increment on the current page; partial digits wrap at their real width.
   always_comb begin
      digits_inc = digits_q;
      for (int g = 0; g < NDIG; g++) begin
         if ((g / SW_N) == int'(page_q) && sw_rise[g % SW_N]) begin
            digits_inc[4*g +: 4] = (digits_q[4*g +: 4] + 4'd1) & DIG_MASK[4*g +: 4];
         end
      end
   end

   // Main controller FSM with registered handshake and pulse outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         owner_q   <= S_M_CLEAR;
         page_q    <= '0;
         digits_q  <= '0;
         rd_q      <= '0;
         wd_q      <= '0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         mem_clr_q <= 1'b0;
         io_done_q <= 1'b0;
         io_err_q  <= 1'b0;
      end else begin
         io_done_q <= 1'b0;
         io_err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (mode_rise) state_q <= S_M_CLEAR;
            end
            S_M_CLEAR: begin
               if (mode_rise) state_q <= S_M_WRITE;
               else if (step_rise) begin
                  state_q   <= S_ISSUE;
                  owner_q   <= S_M_CLEAR;
                  mem_clr_q <= 1'b1;
                  mem_we_q  <= 1'b0;
                  digits_q  <= '0;
               end
            end
            S_M_WRITE: begin
               if (mode_rise) state_q <= S_M_READ;
               else if (step_rise) begin
                  state_q <= S_ENTRY;
                  owner_q <= S_M_WRITE;
                  page_q  <= '0;
               end
            end
            S_M_READ: begin
               if (mode_rise) state_q <= S_M_CLEAR;
               else if (step_rise) begin
                  state_q <= S_ENTRY;
                  owner_q <= S_M_READ;
                  page_q  <= '0;
               end
            end
            S_ENTRY: begin
               if (mode_rise) state_q <= owner_q;
               else begin
                  digits_q <= digits_inc;
                  if (step_rise) begin
                     if (page_q == last_pg) begin
                        state_q   <= S_ISSUE;
                        mem_we_q  <= (owner_q == S_M_WRITE);
                        mem_clr_q <= 1'b0;
                     end else begin
                        page_q <= page_q + 4'd1;
                     end
                  end
               end
            end
            S_ISSUE: begin
               mem_req_q <= 1'b1;
               wd_q      <= '0;
               state_q   <= S_WAIT;
            end
            S_WAIT: begin
               if (mem_done) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  mem_clr_q <= 1'b0;
                  io_done_q <= 1'b1;
                  if (owner_q == S_M_READ) begin
                     rd_q    <= fit_page(mem_rdata);
                     state_q <= S_SHOW;
                  end else begin
                     state_q <= owner_q;
                  end
               end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  mem_clr_q <= 1'b0;
                  io_err_q  <= 1'b1;
                  state_q   <= owner_q;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            S_SHOW: begin
               if (mode_rise)      state_q <= owner_q;
               else if (step_rise) state_q <= S_M_READ;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Display, mode and stage decode from registered state.
   always_comb begin
      mode_out  = MODE_IDLE;
      stage_out = 4'd0;
      disp_data = '0;
      case (state_q)
         S_IDLE:    mode_out = MODE_IDLE;
         S_M_CLEAR: mode_out = MODE_CLEAR;
         S_M_WRITE: mode_out = MODE_WRITE;
         S_M_READ:  mode_out = MODE_READ;
         S_ENTRY: begin
            mode_out  = mode_code(owner_q);
            stage_out = page_q + 4'd1;
            disp_data = digits_q[int'(page_q) * PG_W +: PG_W];
         end
         S_SHOW: begin
            mode_out  = mode_code(owner_q);
            disp_data = rd_q;
         end
         default: mode_out = mode_code(owner_q);
      endcase
   end

   assign mem_addr  = digits_q[ADDR_W-1:0];
   assign mem_wdata = digits_q[APG*PG_W +: DATA_W];
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_clr   = mem_clr_q;
   assign io_done   = io_done_q;
   assign io_err    = io_err_q;

endmodule

// File: tb/tb_io_entry_ctrl.sv
// Directed bench for io_entry_ctrl with default parameters.
module tb_io_entry_ctrl;

   localparam int TIMEOUT = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_mode = 1'b0;
   logic        key_step = 1'b0;
   logic [3:0]  sw = 4'd0;
   logic        mem_done = 1'b0;
   logic [15:0] mem_rdata = 16'd0;
   logic [1:0]  mode_out;
   logic [3:0]  stage_out;
   logic [24:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_req, mem_we, mem_clr;
   logic [15:0] disp_data;
   logic        io_done, io_err;

   int vectors = 0;
   int miscompares = 0;

   io_entry_ctrl #(.ADDR_W(25), .DATA_W(16), .SW_N(4), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .key_mode(key_mode), .key_step(key_step), .sw(sw),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .mode_out(mode_out),
      .stage_out(stage_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_clr(mem_clr),
      .disp_data(disp_data), .io_done(io_done), .io_err(io_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_mode();
      tick();
      key_mode = 1'b1;
      tick();
      key_mode = 1'b0;
   endtask

   task automatic press_step();
      tick();
      key_step = 1'b1;
      tick();
      key_step = 1'b0;
   endtask

   task automatic pulse_sw(input int i);
      tick();
      sw[i] = 1'b1;
      tick();
      sw[i] = 1'b0;
   endtask

   task automatic test_reset();
      logic [1:0] exp_modes [4];
      rst = 1'b1;
      tick(); tick();
      vectors++; if (mode_out !== 2'b11) begin miscompares++; $display("FAIL rst_mode got=%h exp=3", mode_out); end
      vectors++; if (stage_out !== 4'd0) begin miscompares++; $display("FAIL rst_stage got=%h exp=0", stage_out); end
      vectors++; if ({mem_req, mem_we, mem_clr, io_done, io_err} !== 5'b0) begin miscompares++; $display("FAIL rst_ctrl got=%b exp=00000", {mem_req, mem_we, mem_clr, io_done, io_err}); end
      vectors++; if (mem_addr !== 25'd0 || mem_wdata !== 16'd0 || disp_data !== 16'd0) begin miscompares++; $display("FAIL rst_data got=%h/%h/%h exp=0", mem_addr, mem_wdata, disp_data); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      exp_modes[0] = 2'b00; exp_modes[1] = 2'b10; exp_modes[2] = 2'b01; exp_modes[3] = 2'b00;
      for (int i = 0; i < 4; i++) begin
         press_mode();
         vectors++; if (mode_out !== exp_modes[i]) begin miscompares++; $display("FAIL mode_cycle%0d got=%h exp=%h", i, mode_out, exp_modes[i]); end
         vectors++; if (stage_out !== 4'd0) begin miscompares++; $display("FAIL mode_stage%0d got=%h exp=0", i, stage_out); end
      end
   endtask

   task automatic test_write();
      press_mode();
      vectors++; if (mode_out !== 2'b10) begin miscompares++; $display("FAIL wr_mode got=%h exp=2", mode_out); end
      press_step();
      vectors++; if (stage_out !== 4'd1) begin miscompares++; $display("FAIL wr_stage1 got=%h exp=1", stage_out); end
      repeat (3) pulse_sw(0);
      pulse_sw(3);
      vectors++; if (disp_data !== 16'h1003) begin miscompares++; $display("FAIL wr_page1 got=%h exp=1003", disp_data); end
      press_step();
      vectors++; if (stage_out !== 4'd2 || disp_data !== 16'h0000) begin miscompares++; $display("FAIL wr_page2 got=%h/%h exp=2/0000", stage_out, disp_data); end
      pulse_sw(2);
      vectors++; if (disp_data !== 16'h0100) begin miscompares++; $display("FAIL wr_bit24_set got=%h exp=0100", disp_data); end
      pulse_sw(2);
      vectors++; if (disp_data !== 16'h0000) begin miscompares++; $display("FAIL wr_bit24_wrap got=%h exp=0000", disp_data); end
      pulse_sw(3);
      vectors++; if (disp_data !== 16'h0000) begin miscompares++; $display("FAIL wr_beyond_width got=%h exp=0000", disp_data); end
      press_step();
      vectors++; if (stage_out !== 4'd3) begin miscompares++; $display("FAIL wr_stage3 got=%h exp=3", stage_out); end
      repeat (5) pulse_sw(1);
      vectors++; if (disp_data !== 16'h0050) begin miscompares++; $display("FAIL wr_data_page got=%h exp=0050", disp_data); end
      press_step();
      vectors++; if (stage_out !== 4'd0 || mem_req !== 1'b0 || mem_we !== 1'b1) begin miscompares++; $display("FAIL wr_issue got=st%h req%b we%b exp=st0 req0 we1", stage_out, mem_req, mem_we); end
      tick();
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 25'h0001003 || mem_wdata !== 16'h0050 || mem_we !== 1'b1 || mem_clr !== 1'b0) begin miscompares++; $display("FAIL wr_req got=%b %h %h %b%b exp=1 0001003 0050 10", mem_req, mem_addr, mem_wdata, mem_we, mem_clr); end
      repeat (6) tick();
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 25'h0001003) begin miscompares++; $display("FAIL wr_hold got=%b %h exp=1 0001003", mem_req, mem_addr); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      vectors++; if (io_done !== 1'b1 || mem_req !== 1'b0 || mode_out !== 2'b10) begin miscompares++; $display("FAIL wr_done got=done%b req%b mode%h exp=1 0 2", io_done, mem_req, mode_out); end
      tick();
      vectors++; if (io_done !== 1'b0) begin miscompares++; $display("FAIL wr_done_pulse got=%b exp=0", io_done); end
   endtask

   task automatic test_read();
      press_mode();
      vectors++; if (mode_out !== 2'b01) begin miscompares++; $display("FAIL rd_mode got=%h exp=1", mode_out); end
      press_step();
      vectors++; if (stage_out !== 4'd1 || disp_data !== 16'h1003) begin miscompares++; $display("FAIL rd_page1 got=%h/%h exp=1/1003", stage_out, disp_data); end
      press_step();
      press_step();
      vectors++; if (stage_out !== 4'd0 || mem_we !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL rd_issue got=st%h we%b req%b exp=0 0 0", stage_out, mem_we, mem_req); end
      tick();
      vectors++; if (mem_req !== 1'b1 || mem_addr !== 25'h0001003) begin miscompares++; $display("FAIL rd_req got=%b %h exp=1 0001003", mem_req, mem_addr); end
      mem_rdata = 16'hBEEF;
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      mem_rdata = 16'h0000;
      vectors++; if (disp_data !== 16'hBEEF || io_done !== 1'b1 || mode_out !== 2'b01) begin miscompares++; $display("FAIL rd_show got=%h done%b mode%h exp=BEEF 1 1", disp_data, io_done, mode_out); end
      press_step();
      vectors++; if (disp_data !== 16'h0000 || mode_out !== 2'b01 || stage_out !== 4'd0) begin miscompares++; $display("FAIL rd_back got=%h %h %h exp=0000 1 0", disp_data, mode_out, stage_out); end
   endtask

   task automatic test_switch_edges();
      press_step();
      vectors++; if (disp_data !== 16'h1003) begin miscompares++; $display("FAIL sw_entry got=%h exp=1003", disp_data); end
      tick();
      sw[0] = 1'b1;
      repeat (20) tick();
      sw[0] = 1'b0;
      vectors++; if (disp_data !== 16'h1004) begin miscompares++; $display("FAIL sw_held got=%h exp=1004", disp_data); end
      pulse_sw(1);
      vectors++; if (disp_data !== 16'h1014) begin miscompares++; $display("FAIL sw_one got=%h exp=1014", disp_data); end
      repeat (15) pulse_sw(1);
      vectors++; if (disp_data !== 16'h1004) begin miscompares++; $display("FAIL sw_wrap16 got=%h exp=1004", disp_data); end
      tick();
      sw = 4'b0101;
      tick();
      sw = 4'b0000;
      vectors++; if (disp_data !== 16'h1105) begin miscompares++; $display("FAIL sw_simul got=%h exp=1105", disp_data); end
      press_mode();
      vectors++; if (mode_out !== 2'b01 || stage_out !== 4'd0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL sw_abort got=%h %h %b exp=1 0 0", mode_out, stage_out, mem_req); end
   endtask

   task automatic test_timeout();
      int  cnt;
      bit  seen_done;
      bit  err_at_fall;
      bit  fell;
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      vectors++; if (io_done !== 1'b0 || mode_out !== 2'b01) begin miscompares++; $display("FAIL to_stray_done got=%b %h exp=0 1", io_done, mode_out); end
      press_step(); press_step(); press_step();
      tick();
      cnt = 0; seen_done = 0; err_at_fall = 0; fell = 0;
      for (int i = 0; i < TIMEOUT + 20; i++) begin
         if (io_done) seen_done = 1;
         if (!mem_req) begin
            fell = 1;
            err_at_fall = io_err;
            break;
         end
         cnt++;
         tick();
      end
      vectors++; if (!fell || cnt != TIMEOUT) begin miscompares++; $display("FAIL to_cycles got=%0d exp=%0d", cnt, TIMEOUT); end
      vectors++; if (err_at_fall !== 1'b1) begin miscompares++; $display("FAIL to_err got=%b exp=1", err_at_fall); end
      vectors++; if (seen_done || io_done !== 1'b0) begin miscompares++; $display("FAIL to_no_done got=%b exp=0", seen_done | io_done); end
      tick();
      vectors++; if (io_err !== 1'b0 || mode_out !== 2'b01) begin miscompares++; $display("FAIL to_after got=err%b mode%h exp=0 1", io_err, mode_out); end
   endtask

   task automatic test_clear();
      press_mode();
      vectors++; if (mode_out !== 2'b00) begin miscompares++; $display("FAIL clr_mode got=%h exp=0", mode_out); end
      press_step();
      vectors++; if (mem_clr !== 1'b1 || mem_addr !== 25'd0 || mem_wdata !== 16'd0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL clr_issue got=clr%b %h %h req%b exp=1 0 0 0", mem_clr, mem_addr, mem_wdata, mem_req); end
      tick();
      vectors++; if (mem_req !== 1'b1 || mem_clr !== 1'b1) begin miscompares++; $display("FAIL clr_req got=%b%b exp=11", mem_req, mem_clr); end
      press_mode();
      vectors++; if (mode_out !== 2'b00 || mem_req !== 1'b1) begin miscompares++; $display("FAIL clr_mode_ignored got=%h %b exp=0 1", mode_out, mem_req); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      vectors++; if (io_done !== 1'b1 || mem_req !== 1'b0 || mode_out !== 2'b00) begin miscompares++; $display("FAIL clr_done got=%b %b %h exp=1 0 0", io_done, mem_req, mode_out); end
   endtask

   task automatic test_back_to_back();
      press_mode();
      press_step();
      vectors++; if (stage_out !== 4'd1) begin miscompares++; $display("FAIL b2b_entry got=%h exp=1", stage_out); end
      tick();
      key_mode = 1'b1;
      key_step = 1'b1;
      tick();
      key_mode = 1'b0;
      key_step = 1'b0;
      vectors++; if (mode_out !== 2'b10 || stage_out !== 4'd0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL b2b_abort got=%h %h %b exp=2 0 0", mode_out, stage_out, mem_req); end
      tick(); tick();
      vectors++; if (mem_req !== 1'b0 || stage_out !== 4'd0 || mode_out !== 2'b10) begin miscompares++; $display("FAIL b2b_dropped got=%b %h %h exp=0 0 2", mem_req, stage_out, mode_out); end
      press_mode();
      press_step(); press_step(); press_step();
      tick();
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rstw_req got=%b exp=1", mem_req); end
      rst = 1'b1;
      #1;
      vectors++; if (mem_req !== 1'b0 || mode_out !== 2'b11 || io_done !== 1'b0) begin miscompares++; $display("FAIL rstw_async got=%b %h %b exp=0 3 0", mem_req, mode_out, io_done); end
      tick();
      vectors++; if ({mem_req, mem_we, mem_clr, io_done, io_err} !== 5'b0 || disp_data !== 16'd0 || mem_addr !== 25'd0) begin miscompares++; $display("FAIL rstw_outs got=%b %h %h exp=0", {mem_req, mem_we, mem_clr, io_done, io_err}, disp_data, mem_addr); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      vectors++; if (io_done !== 1'b0 || mode_out !== 2'b11) begin miscompares++; $display("FAIL rstw_release got=%b %h exp=0 3", io_done, mode_out); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_switch_edges();
      test_timeout();
      test_clear();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
